// File: rtl/cp0_pkg.sv
// Shared definitions for the cp0 system-control coprocessor: register indices,
// bit-field positions, exception codes and the exception-level state type.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_EXC    = 1'b1
  } exl_state_e;

endpackage

// File: rtl/cp0.sv
// cp0: SR/Cause/EPC/PRId registers, interrupt gating and exception level.
// Optional ExcCode capture into Cause[6:2] is enabled by defining CP0_EXCCODE_EN.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4C59_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A,
  input  logic        we,
  input  logic [31:0] DIn,
  input  logic [31:2] PC,
  input  logic [7:2]  HWInt,
  input  logic        EXLSet,
  input  logic        EXLClr,
`ifdef CP0_EXCCODE_EN
  input  logic [6:2]  ExcCode,
`endif
  output logic        IntReq,
  output logic [31:2] EPC,
  output logic [31:0] DOut
);

  exl_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q;
  logic [29:0] epc_q, epc_d;
  logic [4:0]  exc_code;
  logic        exl;
  logic        sr_wr, epc_wr;

  assign sr_wr  = we && (A == CP0_SR);
  assign epc_wr = we && (A == CP0_EPC);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  // EXLSet beats EXLClr, which beats the EXL bit of an SR write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (EXLSet)                    state_d = ST_EXC;
        else if (EXLClr)               state_d = ST_NORMAL;
        else if (sr_wr && DIn[EXL_BIT]) state_d = ST_EXC;
      end
      ST_EXC: begin
        if (EXLSet)                     state_d = ST_EXC;
        else if (EXLClr)                state_d = ST_NORMAL;
        else if (sr_wr && !DIn[EXL_BIT]) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    exl    = (state_q == ST_EXC);
    IntReq = (|(ip_q & im_q)) & ie_q & ~exl;
  end

  always_comb begin
    im_d  = sr_wr ? DIn[IM_HI:IM_LO] : im_q;
    ie_d  = sr_wr ? DIn[IE_BIT] : ie_q;
    epc_d = EXLSet ? PC : (epc_wr ? DIn[31:2] : epc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      ip_q  <= HWInt;
      epc_q <= epc_d;
    end
  end

`ifdef CP0_EXCCODE_EN
  logic [4:0] exc_code_q;
  always_ff @(posedge clk) begin
    if (rst)         exc_code_q <= EXC_INT;
    else if (EXLSet) exc_code_q <= ExcCode;
  end
  assign exc_code = exc_code_q;
`else
  assign exc_code = EXC_INT;
`endif

  assign EPC = epc_q;

  always_comb begin
    DOut = 32'h0;
    unique case (A)
      CP0_SR: begin
        DOut[IM_HI:IM_LO] = im_q;
        DOut[EXL_BIT]     = exl;
        DOut[IE_BIT]      = ie_q;
      end
      CP0_CAUSE: begin
        DOut[IP_HI:IP_LO]   = ip_q;
        DOut[EXC_HI:EXC_LO] = exc_code;
      end
      CP0_EPC:  DOut[31:2] = epc_q;
      CP0_PRID: DOut = PRID;
      default:  DOut = 32'h0;
    endcase
  end

endmodule
